// File: rtl/output_lane_collector_pkg.sv
// Shared defaults, types and small helpers for the output lane collector.
package output_collector_pkg;

  localparam int DEF_NUM_LANES         = 8;
  localparam int DEF_DATA_W            = 16;
  localparam int DEF_FIFO_DEPTH        = 4;
  localparam int DEF_EXPECTED_PER_LANE = 64;
  localparam int DEF_CNT_W             = 16;

  typedef logic [$clog2(DEF_NUM_LANES)-1:0] lane_idx_t;
  typedef logic [DEF_DATA_W-1:0]            data_t;

  // Lane index arithmetic with wrap-around; works for non-power-of-two lane counts.
  function automatic int unsigned wrap_lane(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/output_lane_collector_if.sv
// Lane write streams in, merged ready/valid stream out.
interface output_lane_collector_if
  import output_collector_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DATA_W    = DEF_DATA_W
);
  localparam int LANE_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0]        lane_valid;
  logic [NUM_LANES*DATA_W-1:0] lane_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           out_data;
  logic [LANE_W-1:0]           out_lane;

  // Collector side
  modport master (
    input  lane_valid, lane_data, out_ready,
    output out_valid, out_data, out_lane
  );

  // Producer/consumer side
  modport slave (
    output lane_valid, lane_data, out_ready,
    input  out_valid, out_data, out_lane
  );

endinterface

// File: rtl/output_lane_collector_lane_fifo.sv
// Per-lane synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module lane_fifo
  import output_collector_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign rd_data   = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, data only
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/output_lane_collector.sv
// Merges NUM_LANES push-only lane streams into one tagged ready/valid stream,
// with round-robin arbitration, drop/overflow tracking and run completion detection.
module output_lane_collector
  import output_collector_pkg::*;
#(
  parameter int NUM_LANES         = DEF_NUM_LANES,
  parameter int DATA_W            = DEF_DATA_W,
  parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
  parameter int EXPECTED_PER_LANE = DEF_EXPECTED_PER_LANE,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  output_lane_collector_if.master               bus,
  output logic [NUM_LANES-1:0]                  overflow,
  output logic [CNT_W+$clog2(NUM_LANES)-1:0]    total_count,
  output logic                                  done
);
  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int TOT_W  = CNT_W + LANE_W;

  logic [NUM_LANES-1:0] full_s;
  logic [NUM_LANES-1:0] empty_s;
  logic [NUM_LANES-1:0] pop_s;
  logic [NUM_LANES-1:0] accept_s;
  logic [NUM_LANES-1:0] drop_s;
  logic [DATA_W-1:0]    head_s [NUM_LANES];

  logic                 load_s;
  logic                 found_s;
  logic [LANE_W-1:0]    grant_s;
  logic [LANE_W-1:0]    cand_s;
  logic [LANE_W-1:0]    next_ptr_s;
  logic [LANE_W:0]      add_s;
  logic                 cnt_met_s;
  logic                 finish_s;

  logic                 out_valid_r;
  logic [DATA_W-1:0]    out_data_r;
  logic [LANE_W-1:0]    out_lane_r;
  logic [LANE_W-1:0]    ptr_r;
  logic [CNT_W-1:0]     lane_cnt_r [NUM_LANES];
  logic [NUM_LANES-1:0] overflow_r;
  logic [TOT_W-1:0]     total_r;
  logic                 done_r;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .push    (bus.lane_valid[g]),
      .pop     (pop_s[g]),
      .wr_data (bus.lane_data[g*DATA_W +: DATA_W]),
      .rd_data (head_s[g]),
      .full    (full_s[g]),
      .empty   (empty_s[g])
    );
  end

  // A full lane still accepts when it is the one being popped this cycle
  assign accept_s = bus.lane_valid & (~full_s | pop_s);
  assign drop_s   = bus.lane_valid & full_s & ~pop_s;
  assign load_s   = ~out_valid_r | bus.out_ready;

  // Round-robin pick: scan offsets high to low so the nearest non-empty lane from ptr_r wins
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    cand_s  = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      cand_s  = LANE_W'(wrap_lane(32'(ptr_r), k, NUM_LANES));
      grant_s = empty_s[cand_s] ? grant_s : cand_s;
      found_s = found_s | ~empty_s[cand_s];
    end
  end

  assign next_ptr_s = LANE_W'(wrap_lane(32'(grant_s), 32'd1, NUM_LANES));

  // Pop strobe for the granted lane on an output load
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pop_s[i] = load_s & found_s & (grant_s == LANE_W'(i));
    end
  end

  // Number of lanes accepting a word this cycle
  always_comb begin
    add_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      add_s = add_s + (LANE_W+1)'(accept_s[i]);
    end
  end

  // Completion: every lane reached its quota and nothing is left in flight
  always_comb begin
    cnt_met_s = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      cnt_met_s = cnt_met_s & (lane_cnt_r[i] >= CNT_W'(EXPECTED_PER_LANE));
    end
    finish_s = cnt_met_s & (&empty_s) & ~out_valid_r;
  end

  // Output register and grant pointer; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_lane_r  <= '0;
      ptr_r       <= '0;
    end else if (load_s) begin
      out_valid_r <= found_s;
      if (found_s) begin
        out_data_r <= head_s[grant_s];
        out_lane_r <= grant_s;
        ptr_r      <= next_ptr_s;
      end
    end
  end

  // Accepted-word counters, sticky overflow and done
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_LANES; i++) lane_cnt_r[i] <= '0;
      overflow_r <= '0;
      total_r    <= '0;
      done_r     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (accept_s[i] && (lane_cnt_r[i] != {CNT_W{1'b1}})) begin
          lane_cnt_r[i] <= lane_cnt_r[i] + 1'b1;
        end
      end
      overflow_r <= overflow_r | drop_s;
      total_r    <= total_r + TOT_W'(add_s);
      done_r     <= done_r | finish_s;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_lane  = out_lane_r;
  assign overflow      = overflow_r;
  assign total_count   = total_r;
  assign done          = done_r;

endmodule

// File: tb/tb_output_lane_collector.sv
// Directed bench for output_lane_collector with hand-computed expectations.
module tb_output_lane_collector;
  import output_collector_pkg::*;

  localparam int NL = 8;
  localparam int DW = 16;
  localparam int LW = 3;
  localparam int TW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [NL-1:0] overflow;
  logic [TW-1:0] total_count;
  logic          done;

  output_lane_collector_if #(.NUM_LANES(NL), .DATA_W(DW)) bus ();

  output_lane_collector #(
    .NUM_LANES         (NL),
    .DATA_W            (DW),
    .FIFO_DEPTH        (4),
    .EXPECTED_PER_LANE (4),
    .CNT_W             (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .overflow    (overflow),
    .total_count (total_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] bq_data [$];
  logic [LW-1:0] bq_lane [$];
  int            bq_cyc  [$];
  int            done_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    bq_data.delete();
    bq_lane.delete();
    bq_cyc.delete();
    done_cyc = -1;
  endtask

  // Record the beat present in this cycle, then advance past the next edge
  task automatic sample_cycle(input int cyc);
    @(negedge clk);
    if (bus.out_valid === 1'b1) begin
      bq_data.push_back(bus.out_data);
      bq_lane.push_back(bus.out_lane);
      bq_cyc.push_back(cyc);
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    tick();
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) sample_cycle(i);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Lane 2 gets 3 words, lane 4 gets 6 words (overflows) while the output stalls
  task automatic load_lanes_2_4();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.lane_valid = (c < 3) ? 8'h14 : 8'h10;
      bus.lane_data[2*DW +: DW] = 16'(16'h2200 + c);
      bus.lane_data[4*DW +: DW] = 16'(16'h4400 + c);
      tick();
    end
    bus.lane_valid = 8'h00;
  endtask

  task automatic check_cleared(input string pfx);
    @(negedge clk);
    chk({pfx, "_valid"},    32'(bus.out_valid), 32'd0);
    chk({pfx, "_total"},    32'(total_count),   32'd0);
    chk({pfx, "_overflow"}, 32'(overflow),      32'd0);
    chk({pfx, "_done"},     32'(done),          32'd0);
    tick();
    bus.out_ready = 1'b1;
    clear_beats();
    collect(8);
    chk({pfx, "_stale"}, 32'(bq_data.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    bus.lane_valid = '0;
    bus.lane_data  = '0;
    bus.out_ready  = 1'b0;
    done_cyc       = -1;
    tick();
    tick();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_valid",    32'(bus.out_valid), 32'd0);
    chk("rst_data",     32'(bus.out_data),  32'd0);
    chk("rst_lane",     32'(bus.out_lane),  32'd0);
    chk("rst_overflow", 32'(overflow),      32'd0);
    chk("rst_total",    32'(total_count),   32'd0);
    chk("rst_done",     32'(done),          32'd0);
    tick();

    // Single word on lane 3: two-cycle latency, exactly one beat
    bus.out_ready = 1'b1;
    bus.lane_valid = 8'h08;
    bus.lane_data[3*DW +: DW] = 16'h1234;
    tick();
    bus.lane_valid = 8'h00;
    @(negedge clk);
    chk("single_latency", 32'(bus.out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data",  32'(bus.out_data),  32'h1234);
    chk("single_lane",  32'(bus.out_lane),  32'd3);
    chk("single_total", 32'(total_count),   32'd1);
    tick();
    @(negedge clk);
    chk("single_onebeat", 32'(bus.out_valid), 32'd0);
    tick();

    // All lanes at once
    do_flush();
    bus.lane_valid = 8'hFF;
    for (int i = 0; i < NL; i++) bus.lane_data[i*DW +: DW] = 16'(16'h0100 + i);
    tick();
    bus.lane_valid = 8'h00;
    clear_beats();
    collect(12);
    chk("all_count", 32'(bq_data.size()), 32'd8);
    if (bq_data.size() == 8) begin
      for (int i = 0; i < NL; i++) begin
        chk("all_lane", 32'(bq_lane[i]), 32'(i));
        chk("all_data", 32'(bq_data[i]), 32'(16'h0100 + i));
      end
      chk("all_back2back", 32'(bq_cyc[7] - bq_cyc[0]), 32'd7);
    end
    chk("all_overflow", 32'(overflow), 32'd0);

    // Backpressure: A0 in the output register, A1-A4 buffered, A5 dropped
    do_flush();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.lane_valid = 8'h01;
      bus.lane_data[DW-1:0] = 16'(16'h00A0 + k);
      tick();
    end
    bus.lane_valid = 8'h00;
    @(negedge clk);
    chk("bp_valid",    32'(bus.out_valid), 32'd1);
    chk("bp_data",     32'(bus.out_data),  32'h00A0);
    chk("bp_overflow", 32'(overflow),      32'h01);
    chk("bp_total",    32'(total_count),   32'd5);
    tick();
    tick();
    @(negedge clk);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_hold_data",  32'(bus.out_data),  32'h00A0);
    tick();
    bus.out_ready = 1'b1;
    clear_beats();
    collect(8);
    chk("bp_drain_count", 32'(bq_data.size()), 32'd5);
    if (bq_data.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("bp_drain_data", 32'(bq_data[i]), 32'(16'h00A0 + i));
        chk("bp_drain_lane", 32'(bq_lane[i]), 32'd0);
      end
    end
    chk("bp_overflow_sticky", 32'(overflow), 32'h01);

    // Fairness between lanes 1 and 5
    do_flush();
    bus.out_ready = 1'b1;
    clear_beats();
    for (int c = 0; c < 16; c++) begin
      bus.lane_valid = (c < 4) ? 8'h22 : 8'h00;
      bus.lane_data[1*DW +: DW] = 16'(16'h1000 + c);
      bus.lane_data[5*DW +: DW] = 16'(16'h5000 + c);
      sample_cycle(c);
    end
    chk("rr_count", 32'(bq_data.size()), 32'd8);
    if (bq_data.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("rr_lane", 32'(bq_lane[i]), (i % 2 == 0) ? 32'd1 : 32'd5);
        chk("rr_data", 32'(bq_data[i]), (i % 2 == 0) ? 32'(16'h1000 + i/2) : 32'(16'h5000 + i/2));
      end
    end
    chk("rr_overflow", 32'(overflow), 32'd0);

    // Completion with 4 words per lane
    do_flush();
    @(negedge clk);
    chk("cmp_done_pre", 32'(done), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    clear_beats();
    for (int c = 0; c < 48; c++) begin
      bus.lane_valid = (c < 4) ? 8'hFF : 8'h00;
      for (int i = 0; i < NL; i++) bus.lane_data[i*DW +: DW] = 16'((i << 8) | c);
      sample_cycle(c);
    end
    chk("cmp_beats",    32'(bq_data.size()), 32'd32);
    chk("cmp_total",    32'(total_count),    32'd32);
    chk("cmp_overflow", 32'(overflow),       32'd0);
    if (bq_cyc.size() == 32) chk("cmp_done_edge", 32'(done_cyc), 32'(bq_cyc[31] + 2));
    clear_beats();
    bus.lane_valid = 8'h40;
    bus.lane_data[6*DW +: DW] = 16'hBEEF;
    sample_cycle(0);
    bus.lane_valid = 8'h00;
    for (int c = 1; c < 5; c++) sample_cycle(c);
    chk("cmp_extra_count", 32'(bq_data.size()), 32'd1);
    if (bq_data.size() == 1) begin
      chk("cmp_extra_data", 32'(bq_data[0]), 32'hBEEF);
      chk("cmp_extra_lane", 32'(bq_lane[0]), 32'd6);
    end
    chk("cmp_done_sticky", 32'(done), 32'd1);

    // Flush mid-stream, with done still set from the previous run
    load_lanes_2_4();
    @(negedge clk);
    chk("fl_pre_overflow", 32'(overflow[4]), 32'd1);
    chk("fl_pre_done",     32'(done),        32'd1);
    tick();
    do_flush();
    check_cleared("fl");

    // Same scenario cleared by rst
    load_lanes_2_4();
    @(negedge clk);
    chk("rs_pre_total", 32'(total_count != '0), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("rs");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
